// File: rtl/xor_crc_engine_pkg.sv
// Shared types and constants for the bit-serial XOR/LFSR checksum engine.
`timescale 1ns/1ps
package xor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0]  CRC8_POLY        = 8'h07;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xor_crc_engine_crc_bit_step.sv
// One-bit LFSR update: shift the register left and fold in the polynomial
// when the outgoing MSB differs from the incoming data bit.
`timescale 1ns/1ps
module crc_bit_step #(
  parameter int unsigned CRC_W = 8
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic             data_bit,
  input  logic [CRC_W-1:0] poly,
  output logic [CRC_W-1:0] crc_out
);

  logic fb;

  always_comb begin
    fb      = crc_in[CRC_W-1] ^ data_bit;
    crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
  end

endmodule

// File: rtl/xor_crc_engine.sv
// Bit-serial CRC engine: accepts DATA_W-bit words over valid/ready, folds one
// bit per clock into the CRC register and pulses crc_valid at end of frame.
`timescale 1ns/1ps
module xor_crc_engine
  import xor_pkg::*;
#(
  parameter int unsigned      CRC_W     = 8,
  parameter logic [CRC_W-1:0] POLY      = CRC_W'(CRC8_POLY),
  parameter logic [CRC_W-1:0] INIT      = '0,
  parameter logic [CRC_W-1:0] XOR_OUT   = '0,
  parameter int unsigned      DATA_W    = 8,
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              busy,
  output logic              crc_valid,
  output logic [CRC_W-1:0]  crc_out
);

  localparam int unsigned      CNT_W    = (DATA_W > 1) ? clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t             state, state_next;
  logic [CRC_W-1:0]   crc_reg;
  logic [CRC_W-1:0]   crc_step;
  logic [CNT_W-1:0]   bit_cnt;
  logic               last_q;
  logic [DATA_W-1:0]  shift_q;
  logic [DATA_W-1:0]  shift_next;
  logic               data_bit;
  logic               accept;
  logic               last_bit;

  // The word is shifted toward the serial end each cycle, so the bit taken
  // is always data[DATA_W-1-bit_cnt] (MSB first) or data[bit_cnt] (LSB first).
  always_comb begin
    data_bit   = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
    shift_next = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
  end

  crc_bit_step #(
    .CRC_W(CRC_W)
  ) u_step (
    .crc_in   (crc_reg),
    .data_bit (data_bit),
    .poly     (POLY),
    .crc_out  (crc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    crc_valid  = 1'b0;
    accept     = 1'b0;
    last_bit   = (bit_cnt == LAST_BIT);
    case (state)
      IDLE, WAIT: begin
        in_ready = !clear;
        accept   = in_valid && !clear;
        if (accept) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = last_q ? DONE : WAIT;
      end
      DONE: begin
        crc_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg <= INIT;
      bit_cnt <= '0;
      last_q  <= 1'b0;
      shift_q <= '0;
    end else if (clear) begin
      crc_reg <= INIT;
      bit_cnt <= '0;
    end else if (accept) begin
      if (state == IDLE) crc_reg <= INIT;
      shift_q <= in_data;
      last_q  <= in_last;
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      crc_reg <= crc_step;
      shift_q <= shift_next;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign crc_out = crc_reg ^ XOR_OUT;

endmodule

// File: tb/tb_xor_crc_engine.sv
// Scoreboard bench: a CRC-8 and a CRC-16/CCITT engine driven with directed
// and random frames, checked against a polynomial long-division model.
`timescale 1ns/1ps
module tb_xor_crc_engine;

  typedef byte unsigned msg_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_clear = 1'b0, a_valid = 1'b0, a_last = 1'b0;
  logic [7:0]  a_data = '0;
  logic        a_ready, a_busy, a_cv;
  logic [7:0]  a_out;

  logic        b_clear = 1'b0, b_valid = 1'b0, b_last = 1'b0;
  logic [7:0]  b_data = '0;
  logic        b_ready, b_busy, b_cv;
  logic [15:0] b_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  always #5 clk = ~clk;

  xor_crc_engine dut_a (
    .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .in_last(a_last), .busy(a_busy), .crc_valid(a_cv), .crc_out(a_out)
  );

  xor_crc_engine #(
    .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000),
    .DATA_W(8), .MSB_FIRST(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_last(b_last), .busy(b_busy), .crc_valid(b_cv), .crc_out(b_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: CRC = (init * x^n + msg * x^w) mod G, by long division over
  // the augmented message bit string.
  function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly,
                                          input logic [31:0] init, input msg_t msg);
    bit bits[$];
    logic [31:0] r;
    int n;
    n = msg.size() * 8;
    foreach (msg[i]) for (int k = 7; k >= 0; k--) bits.push_back(msg[i][k]);
    for (int k = 0; k < w; k++) bits.push_back(1'b0);
    for (int k = 0; k < w; k++) bits[k] ^= init[w-1-k];
    for (int i = 0; i < n; i++) begin
      if (bits[i]) begin
        bits[i] = 1'b0;
        for (int j = 1; j <= w; j++) bits[i+j] ^= poly[w-j];
      end
    end
    r = '0;
    for (int k = 0; k < w; k++) r[w-1-k] = bits[n+k];
    return r;
  endfunction

  function automatic msg_t str2msg(input string s);
    msg_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic drive(input int sel, input bit v, input byte unsigned d, input bit l);
    if (sel == 0) begin a_valid = v; a_data = d; a_last = l; end
    else          begin b_valid = v; b_data = d; b_last = l; end
  endtask

  task automatic send(input int sel, input msg_t msg, input int maxgap, input bit push);
    for (int i = 0; i < msg.size(); i++) begin
      bit ok;
      int g;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) begin @(negedge clk); drive(sel, 0, 8'h00, 0); end
      ok = 0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge clk);
        drive(sel, 1, msg[i], i == msg.size() - 1);
        #1 ok = (sel == 0) ? a_ready : b_ready;
        @(posedge clk);
      end
      if (!ok) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: got no in_ready expected in_ready within 100 cycles");
      end
    end
    @(negedge clk);
    drive(sel, 0, 8'h00, 0);
    if (push) begin
      if (sel == 0) exp_a.push_back(ref_crc(8, 32'h07, 32'h0, msg));
      else          exp_b.push_back(ref_crc(16, 32'h1021, 32'hFFFF, msg));
    end
  endtask

  // Monitor: busy run length, in_ready low during SHIFT, scoreboard pop on crc_valid.
  int a_run = 0, a_last_run = 0, b_run = 0, b_last_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      a_run = 0; a_last_run = 0; b_run = 0; b_last_run = 0;
    end else begin
      if (a_busy) begin a_run++; chk("a_ready_in_shift", 32'(a_ready), 0); end
      else if (a_run != 0) begin a_last_run = a_run; a_run = 0; end
      if (b_busy) begin b_run++; chk("b_ready_in_shift", 32'(b_ready), 0); end
      else if (b_run != 0) begin b_last_run = b_run; b_run = 0; end
      if (a_cv) begin
        chk("a_busy_len", 32'(a_last_run), 8);
        chk("a_ready_in_done", 32'(a_ready), 0);
        if (exp_a.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL a_unexpected_crc_valid: got crc_out=%0h expected no pulse", a_out);
        end else chk("a_crc", 32'(a_out), exp_a.pop_front());
      end
      if (b_cv) begin
        chk("b_busy_len", 32'(b_last_run), 8);
        if (exp_b.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_unexpected_crc_valid: got crc_out=%0h expected no pulse", b_out);
        end else chk("b_crc", 32'(b_out), exp_b.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    msg_t m, s9;
    s9 = str2msg("123456789");

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(a_ready), 1);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_valid", 32'(a_cv), 0);
    chk("rst_crc_out", 32'(a_out), 32'h00);
    chk("rst_b_crc_out", 32'(b_out), 32'hFFFF);
    rst = 1'b0;

    // Single-word frames, known values
    m = {8'h01};
    send(0, m, 0, 1);
    chk("ref_01", ref_crc(8, 32'h07, 32'h0, m), 32'h07);
    repeat (12) @(negedge clk);
    chk("a_hold_in_idle", 32'(a_out), 32'h07);
    m = {8'h00};
    send(0, m, 0, 1);
    repeat (12) @(negedge clk);

    // Check string twice, valid held high between words
    chk("ref_check8", ref_crc(8, 32'h07, 32'h0, s9), 32'hF4);
    send(0, s9, 0, 1);
    send(0, s9, 0, 1);
    repeat (12) @(negedge clk);

    // Random frames with random inter-word gaps
    for (int f = 0; f < 8; f++) begin
      m = {};
      for (int i = 0; i < int'($urandom_range(5, 1)); i++) m.push_back(8'($urandom));
      send(0, m, 3, 1);
    end
    repeat (12) @(negedge clk);

    // Clear during SHIFT of word 3: frame discarded, then full resend
    m = {s9[0], s9[1], s9[2]};
    send(0, m, 0, 0);
    repeat (3) @(negedge clk);
    a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    #1;
    chk("clear_ready", 32'(a_ready), 1);
    chk("clear_busy", 32'(a_busy), 0);
    chk("clear_crc_out", 32'(a_out), 32'h00);
    repeat (12) @(negedge clk);
    send(0, s9, 0, 1);
    repeat (12) @(negedge clk);

    // Clear together with in_valid in IDLE: word must not be taken
    a_clear = 1'b1; drive(0, 1, 8'h55, 1);
    #1 chk("clear_blocks_ready", 32'(a_ready), 0);
    @(negedge clk);
    a_clear = 1'b0; drive(0, 0, 8'h00, 0);
    #1;
    chk("clear_idle_busy", 32'(a_busy), 0);
    chk("clear_idle_ready", 32'(a_ready), 1);
    repeat (12) @(negedge clk);

    // CRC-16/CCITT with INIT=FFFF
    chk("ref_check16", ref_crc(16, 32'h1021, 32'hFFFF, s9), 32'h29B1);
    send(1, s9, 1, 1);
    repeat (12) @(negedge clk);

    // rst during SHIFT
    m = {8'hA5};
    send(1, m, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_b_ready", 32'(b_ready), 1);
    chk("rst_mid_b_busy", 32'(b_busy), 0);
    chk("rst_mid_b_valid", 32'(b_cv), 0);
    chk("rst_mid_b_crc_out", 32'(b_out), 32'hFFFF);
    rst = 1'b0;
    send(1, s9, 0, 1);

    repeat (20) @(negedge clk);
    chk("a_queue_empty", 32'(exp_a.size()), 0);
    chk("b_queue_empty", 32'(exp_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
